ether_rx: RTL and testbench
===========================

Name: ether_rx

Overview:
- Receive-side Ethernet header stripper for the 512-bit MSB-first bytestream from the MAC.
- On each frame's first beat it extracts the 14-byte header (bits [511:400]) onto a dedicated header port.
- It realigns the remaining payload left by 112 bits onto an output bytestream.
- Sits between the MAC RX stream and the protocol parsers; it is the inverse of the TX header-prepend block.

Parameters:
COUNT_WIDTH, 32, width of frame/drop statistics counters

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
recv_data  in  512  input beat, byte 0 at [511:504]
recv_valid  in  1  beat valid
recv_sop  in  1  first beat of frame
recv_eop  in  1  last beat of frame
recv_mty  in  8  empty bytes at LSB end on eop beat (0..63), ignored when eop=0
ether_header_data  out  112  extracted header (dst, src, ethertype)
ether_header_valid  out  1  one-cycle pulse, header accepted
ether_data_data  out  512  realigned payload
ether_data_valid  out  1  payload beat valid
ether_data_sop  out  1  first payload beat
ether_data_eop  out  1  last payload beat
ether_data_mty  out  8  empty bytes on eop beat
err  out  1  one-cycle pulse on truncated or dropped frame
frame_count  out  COUNT_WIDTH  good frames emitted, wraps
drop_count  out  COUNT_WIDTH  runt frames dropped, wraps

Behaviour:
- One clock, clk. Reset is synchronous, active-low on reset_n.
- Reset: all outputs 0, internal buf (400 bit) 0, state IDLE. Reset mid-frame discards the frame silently (no eop emitted).
- All outputs registered. Response appears the cycle after the input beat. No backpressure.
- The header and data valid pulses default to 0 every cycle unless set below.
- Header extraction, on every accepted sop beat: ether_header_data <= recv_data[511:400]; header_valid <= 1; buf <= recv_data[399:0].
- IDLE, on valid & sop:
  - If not eop: set first_pend = 1 and go to BODY. No payload beat is emitted this cycle.
  - If eop and mty < 50: emit a single beat {recv_data[399:0], 112'h0}, sop=1, eop=1, mty = mty+14; frame_count++.
  - If eop and mty >= 50 (runt, <= 14 bytes): no header pulse, no payload; err=1; drop_count++. Stay in IDLE.
  - A valid beat without sop is ignored.
- BODY, on valid & !sop:
  - Emit {buf, recv_data[511:400]} with sop = first_pend; clear first_pend.
  - Then buf <= recv_data[399:0].
  - If eop and mty >= 50: that beat has eop=1, mty = mty-50; frame_count++; go to IDLE.
  - If eop and mty < 50: that beat has eop=0; latch last_mty = mty+14; go to LAST.
  - If not eop: stay in BODY.
- BODY with valid low: ether_data_valid=0, state and buf held (gaps allowed).
- BODY on valid & sop (truncated frame):
  - Emit flush beat {buf, 112'h0}, sop = first_pend, eop=1, mty=14; err=1. frame_count is not incremented.
  - In the same cycle, process the new sop beat as in IDLE (header pulse, buf load, state per eop/mty).
  - If the new beat is a single-beat frame, it is dropped: err, drop_count++, go to IDLE.
- LAST:
  - Emit {buf, 112'h0}, sop=0, eop=1, mty=last_mty; frame_count++; go to IDLE.
  - A simultaneous valid sop & !eop beat is accepted: header pulse, buf load, go to BODY.
  - A simultaneous sop & eop beat is dropped (err, drop_count++).
  - A simultaneous non-sop beat is ignored.
- Arithmetic:
  - mty±constant is 8-bit, unsigned.
  - Output mty is always in 0..63.
  - Payload bytes out = frame bytes - 14.
- Counters wrap at 2^COUNT_WIDTH. Both counters may increment in the same cycle.

Test Plan:
- 60-byte frame, single beat sop=eop=1, mty=4, header bytes 0x00..0x0D -> next cycle: header_valid=1, header=0x000102...0D; data valid=1, sop=eop=1, mty=18, data={in[399:0],112'h0}; frame_count=1.
- 128-byte frame, two beats, mty=0 on beat 2:
  - Cycle 1: header pulse only.
  - Cycle 2: {in1[399:0],in2[511:400]}, sop=1, eop=0.
  - Cycle 3: {in2[399:0],112'h0}, eop=1, mty=14.
- 68-byte frame, two beats, beat-2 mty=60 -> single payload beat, sop=eop=1, mty=10; no LAST beat.
- 3-beat frame with 2 idle cycles between beats 2 and 3 -> output valid low during the gap; payload contents correct and contiguous; sop on first payload beat only.
- Frame A (2 beats, no eop) then a sop beat for frame B -> flush beat eop=1, mty=14, err=1; B header pulse in the same cycle; B completes normally; frame_count counts B only.
- Runt sop+eop mty=52 -> no header/data pulses, err=1, drop_count=1. Separately: reset_n low mid-BODY -> all outputs 0 next cycle, the following frame is handled from IDLE.

Source files
------------

// File: rtl/ether_rx.sv
// Ethernet RX header stripper: pulls the 14-byte header off each frame's
// first beat and realigns the remaining payload left by 112 bits onto an
// MSB-first 512-bit output bytestream. No backpressure; all outputs registered.
module ether_rx #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [511:0]           recv_data,
  input  logic                   recv_valid,
  input  logic                   recv_sop,
  input  logic                   recv_eop,
  input  logic [7:0]             recv_mty,
  output logic [111:0]           ether_header_data,
  output logic                   ether_header_valid,
  output logic [511:0]           ether_data_data,
  output logic                   ether_data_valid,
  output logic                   ether_data_sop,
  output logic                   ether_data_eop,
  output logic [7:0]             ether_data_mty,
  output logic                   err,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t       state_r;
  logic [399:0] buf_r;
  logic         first_pend_r;
  logic [7:0]   last_mty_r;
  logic         big_mty_s;

  // An eop beat holding 14 bytes or fewer: a runt on sop, or fits in the held tail
  assign big_mty_s = recv_eop && (recv_mty >= 8'd50);

  // Frame FSM: header capture, payload realignment, flush/drop handling and stats
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r            <= IDLE;
      buf_r              <= 400'd0;
      first_pend_r       <= 1'b0;
      last_mty_r         <= 8'd0;
      ether_header_data  <= 112'd0;
      ether_header_valid <= 1'b0;
      ether_data_data    <= 512'd0;
      ether_data_valid   <= 1'b0;
      ether_data_sop     <= 1'b0;
      ether_data_eop     <= 1'b0;
      ether_data_mty     <= 8'd0;
      err                <= 1'b0;
      frame_count        <= '0;
      drop_count         <= '0;
    end else begin
      ether_header_valid <= 1'b0;
      ether_data_valid   <= 1'b0;
      ether_data_sop     <= 1'b0;
      ether_data_eop     <= 1'b0;
      ether_data_mty     <= 8'd0;
      err                <= 1'b0;
      case (state_r)
        IDLE: begin
          if (recv_valid && recv_sop) begin
            if (!recv_eop) begin
              ether_header_data  <= recv_data[511:400];
              ether_header_valid <= 1'b1;
              buf_r              <= recv_data[399:0];
              first_pend_r       <= 1'b1;
              state_r            <= BODY;
            end else if (!big_mty_s) begin
              // Whole frame in one beat: header plus a single payload beat
              ether_header_data  <= recv_data[511:400];
              ether_header_valid <= 1'b1;
              buf_r              <= recv_data[399:0];
              ether_data_data    <= {recv_data[399:0], 112'd0};
              ether_data_valid   <= 1'b1;
              ether_data_sop     <= 1'b1;
              ether_data_eop     <= 1'b1;
              ether_data_mty     <= recv_mty + 8'd14;
              frame_count        <= frame_count + COUNT_WIDTH'(1);
            end else begin
              // Runt: no room for any payload, so the frame is discarded
              err        <= 1'b1;
              drop_count <= drop_count + COUNT_WIDTH'(1);
            end
          end
        end
        BODY: begin
          if (recv_valid) begin
            if (recv_sop) begin
              // Truncated frame: flush the held tail, then start the new frame
              ether_data_data  <= {buf_r, 112'd0};
              ether_data_valid <= 1'b1;
              ether_data_sop   <= first_pend_r;
              ether_data_eop   <= 1'b1;
              ether_data_mty   <= 8'd14;
              err              <= 1'b1;
              if (!recv_eop) begin
                ether_header_data  <= recv_data[511:400];
                ether_header_valid <= 1'b1;
                buf_r              <= recv_data[399:0];
                first_pend_r       <= 1'b1;
                state_r            <= BODY;
              end else begin
                drop_count <= drop_count + COUNT_WIDTH'(1);
                state_r    <= IDLE;
              end
            end else begin
              ether_data_data  <= {buf_r, recv_data[511:400]};
              ether_data_valid <= 1'b1;
              ether_data_sop   <= first_pend_r;
              first_pend_r     <= 1'b0;
              buf_r            <= recv_data[399:0];
              if (big_mty_s) begin
                // Remaining bytes fit in this beat: frame ends here
                ether_data_eop <= 1'b1;
                ether_data_mty <= recv_mty - 8'd50;
                frame_count    <= frame_count + COUNT_WIDTH'(1);
                state_r        <= IDLE;
              end else if (recv_eop) begin
                // Tail spills into one more output beat
                last_mty_r <= recv_mty + 8'd14;
                state_r    <= LAST;
              end else begin
                state_r <= BODY;
              end
            end
          end
        end
        LAST: begin
          ether_data_data  <= {buf_r, 112'd0};
          ether_data_valid <= 1'b1;
          ether_data_eop   <= 1'b1;
          ether_data_mty   <= last_mty_r;
          frame_count      <= frame_count + COUNT_WIDTH'(1);
          state_r          <= IDLE;
          if (recv_valid && recv_sop) begin
            if (!recv_eop) begin
              ether_header_data  <= recv_data[511:400];
              ether_header_valid <= 1'b1;
              buf_r              <= recv_data[399:0];
              first_pend_r       <= 1'b1;
              state_r            <= BODY;
            end else begin
              // Output lane is busy with the tail, so a single-beat frame is lost
              err        <= 1'b1;
              drop_count <= drop_count + COUNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ether_rx.sv
// Directed testbench for ether_rx: each task drives a scenario and checks
// the registered outputs one cycle after every input beat.
module tb_ether_rx;

  logic         clk;
  logic         reset_n;
  logic [511:0] recv_data;
  logic         recv_valid;
  logic         recv_sop;
  logic         recv_eop;
  logic [7:0]   recv_mty;
  logic [111:0] ether_header_data;
  logic         ether_header_valid;
  logic [511:0] ether_data_data;
  logic         ether_data_valid;
  logic         ether_data_sop;
  logic         ether_data_eop;
  logic [7:0]   ether_data_mty;
  logic         err;
  logic [31:0]  frame_count;
  logic [31:0]  drop_count;

  int n_checks;
  int n_fail;

  ether_rx #(.COUNT_WIDTH(32)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .recv_data          (recv_data),
    .recv_valid         (recv_valid),
    .recv_sop           (recv_sop),
    .recv_eop           (recv_eop),
    .recv_mty           (recv_mty),
    .ether_header_data  (ether_header_data),
    .ether_header_valid (ether_header_valid),
    .ether_data_data    (ether_data_data),
    .ether_data_valid   (ether_data_valid),
    .ether_data_sop     (ether_data_sop),
    .ether_data_eop     (ether_data_eop),
    .ether_data_mty     (ether_data_mty),
    .err                (err),
    .frame_count        (frame_count),
    .drop_count         (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat whose byte i holds (base + i) mod 256, byte 0 in the top byte
  function automatic logic [511:0] pat(input logic [7:0] base);
    logic [511:0] v;
    v = 512'd0;
    for (int i = 0; i < 64; i++) v[511-8*i -: 8] = base + 8'(i);
    return v;
  endfunction

  // Drive one input cycle, then move just past the edge that registers it
  task automatic step(input logic [511:0] d, input logic v, input logic s,
                      input logic e, input logic [7:0] m);
    recv_data  = d;
    recv_valid = v;
    recv_sop   = s;
    recv_eop   = e;
    recv_mty   = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(pat(8'hAA), 1'b1, 1'b1, 1'b0, 8'd0);
    step(pat(8'hAA), 1'b1, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if ({ether_header_valid, ether_data_valid, ether_data_sop, ether_data_eop, err} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000", {ether_header_valid, ether_data_valid, ether_data_sop, ether_data_eop, err});
    end
    n_checks++;
    if (ether_header_data !== 112'd0 || ether_data_data !== 512'd0 || ether_data_mty !== 8'd0) begin
      n_fail++; $display("FAIL reset_data got hdr %h mty %0d want 0", ether_header_data, ether_data_mty);
    end
    n_checks++;
    if (frame_count !== 32'd0 || drop_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", frame_count, drop_count);
    end
    reset_n = 1'b1;
  endtask

  // 60-byte frame in one beat, mty=4
  task automatic test_single_beat();
    logic [511:0] d;
    d = pat(8'h00);
    step(d, 1'b1, 1'b1, 1'b1, 8'd4);
    n_checks++;
    if (ether_header_valid !== 1'b1 || ether_header_data !== 112'h000102030405060708090A0B0C0D) begin
      n_fail++; $display("FAIL single_hdr got %b %h want 1 000102030405060708090a0b0c0d", ether_header_valid, ether_header_data);
    end
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty, err} !== {3'b111, 8'd18, 1'b0}) begin
      n_fail++; $display("FAIL single_ctl got v%b s%b e%b mty%0d err%b want 1 1 1 18 0", ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty, err);
    end
    n_checks++;
    if (ether_data_data !== {d[399:0], 112'd0} || frame_count !== 32'd1) begin
      n_fail++; $display("FAIL single_data got fc %0d data %h want fc 1", frame_count, ether_data_data);
    end
    step(512'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if ({ether_header_valid, ether_data_valid} !== 2'b00) begin
      n_fail++; $display("FAIL single_pulse got %b want 00", {ether_header_valid, ether_data_valid});
    end
  endtask

  // 128-byte frame: two full beats, tail spills into a LAST beat
  task automatic test_two_beat();
    logic [511:0] a, b;
    a = pat(8'h10);
    b = pat(8'h50);
    step(a, 1'b1, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if ({ether_header_valid, ether_data_valid} !== 2'b10 || ether_header_data !== a[511:400]) begin
      n_fail++; $display("FAIL two_c1 got hv%b dv%b hdr %h want 1 0", ether_header_valid, ether_data_valid, ether_header_data);
    end
    step(b, 1'b1, 1'b0, 1'b1, 8'd0);
    n_checks++;
    if ({ether_header_valid, ether_data_valid, ether_data_sop, ether_data_eop} !== 4'b0110 || ether_data_data !== {a[399:0], b[511:400]}) begin
      n_fail++; $display("FAIL two_c2 got hv%b v%b s%b e%b want 0 1 1 0", ether_header_valid, ether_data_valid, ether_data_sop, ether_data_eop);
    end
    step(512'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty} !== {3'b101, 8'd14} || ether_data_data !== {b[399:0], 112'd0}) begin
      n_fail++; $display("FAIL two_c3 got v%b s%b e%b mty%0d want 1 0 1 14", ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty);
    end
    n_checks++;
    if (frame_count !== 32'd2) begin
      n_fail++; $display("FAIL two_fc got %0d want 2", frame_count);
    end
  endtask

  // 68-byte frame: second beat holds 4 bytes, fits without a LAST beat
  task automatic test_short_tail();
    logic [511:0] a, b;
    a = pat(8'h20);
    b = pat(8'h90);
    step(a, 1'b1, 1'b1, 1'b0, 8'd0);
    step(b, 1'b1, 1'b0, 1'b1, 8'd60);
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty} !== {3'b111, 8'd10} || ether_data_data !== {a[399:0], b[511:400]}) begin
      n_fail++; $display("FAIL short_beat got v%b s%b e%b mty%0d want 1 1 1 10", ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty);
    end
    step(512'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if (ether_data_valid !== 1'b0 || frame_count !== 32'd3) begin
      n_fail++; $display("FAIL short_nolast got v%b fc %0d want 0 3", ether_data_valid, frame_count);
    end
  endtask

  // 3-beat frame with two idle cycles between beats 2 and 3
  task automatic test_gap();
    logic [511:0] a, b, c;
    a = pat(8'h30);
    b = pat(8'h70);
    c = pat(8'hB0);
    step(a, 1'b1, 1'b1, 1'b0, 8'd0);
    step(b, 1'b1, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop} !== 3'b110 || ether_data_data !== {a[399:0], b[511:400]}) begin
      n_fail++; $display("FAIL gap_b1 got v%b s%b e%b want 1 1 0", ether_data_valid, ether_data_sop, ether_data_eop);
    end
    for (int i = 0; i < 2; i++) begin
      step(pat(8'hFF), 1'b0, 1'b0, 1'b0, 8'd0);
      n_checks++;
      if (ether_data_valid !== 1'b0) begin
        n_fail++; $display("FAIL gap_idle%0d got v%b want 0", i, ether_data_valid);
      end
    end
    step(c, 1'b1, 1'b0, 1'b1, 8'd0);
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop} !== 3'b100 || ether_data_data !== {b[399:0], c[511:400]}) begin
      n_fail++; $display("FAIL gap_b2 got v%b s%b e%b want 1 0 0", ether_data_valid, ether_data_sop, ether_data_eop);
    end
    step(512'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty} !== {3'b101, 8'd14} || ether_data_data !== {c[399:0], 112'd0} || frame_count !== 32'd4) begin
      n_fail++; $display("FAIL gap_last got v%b s%b e%b mty%0d fc %0d want 1 0 1 14 4", ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty, frame_count);
    end
  endtask

  // Next frame's sop arrives in the same cycle as the previous frame's LAST beat
  task automatic test_back_to_back();
    logic [511:0] x1, x2, y1, y2;
    x1 = pat(8'h01);
    x2 = pat(8'h41);
    y1 = pat(8'h81);
    y2 = pat(8'hC1);
    step(x1, 1'b1, 1'b1, 1'b0, 8'd0);
    step(x2, 1'b1, 1'b0, 1'b1, 8'd30);
    step(y1, 1'b1, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty} !== {3'b101, 8'd44} || ether_data_data !== {x2[399:0], 112'd0}) begin
      n_fail++; $display("FAIL b2b_last got v%b s%b e%b mty%0d want 1 0 1 44", ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty);
    end
    n_checks++;
    if (ether_header_valid !== 1'b1 || ether_header_data !== y1[511:400] || err !== 1'b0 || frame_count !== 32'd5) begin
      n_fail++; $display("FAIL b2b_hdr got hv%b err%b fc %0d want 1 0 5", ether_header_valid, err, frame_count);
    end
    step(y2, 1'b1, 1'b0, 1'b1, 8'd60);
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty} !== {3'b111, 8'd10} || ether_data_data !== {y1[399:0], y2[511:400]} || frame_count !== 32'd6) begin
      n_fail++; $display("FAIL b2b_y got v%b s%b e%b mty%0d fc %0d want 1 1 1 10 6", ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty, frame_count);
    end
  endtask

  // Frame A cut short by frame B's sop
  task automatic test_truncated();
    logic [511:0] a1, a2, b1, b2;
    a1 = pat(8'h05);
    a2 = pat(8'h45);
    b1 = pat(8'h85);
    b2 = pat(8'hC5);
    step(a1, 1'b1, 1'b1, 1'b0, 8'd0);
    step(a2, 1'b1, 1'b0, 1'b0, 8'd0);
    step(b1, 1'b1, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty, err} !== {3'b101, 8'd14, 1'b1} || ether_data_data !== {a2[399:0], 112'd0}) begin
      n_fail++; $display("FAIL trunc_flush got v%b s%b e%b mty%0d err%b want 1 0 1 14 1", ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty, err);
    end
    n_checks++;
    if (ether_header_valid !== 1'b1 || ether_header_data !== b1[511:400] || frame_count !== 32'd6) begin
      n_fail++; $display("FAIL trunc_hdr got hv%b fc %0d want 1 6", ether_header_valid, frame_count);
    end
    step(b2, 1'b1, 1'b0, 1'b1, 8'd20);
    n_checks++;
    if ({ether_data_valid, ether_data_sop, ether_data_eop, err} !== 4'b1100 || ether_data_data !== {b1[399:0], b2[511:400]}) begin
      n_fail++; $display("FAIL trunc_b1 got v%b s%b e%b err%b want 1 1 0 0", ether_data_valid, ether_data_sop, ether_data_eop, err);
    end
    step(512'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if ({ether_data_valid, ether_data_eop, ether_data_mty} !== {2'b11, 8'd34} || ether_data_data !== {b2[399:0], 112'd0} || frame_count !== 32'd7 || drop_count !== 32'd0) begin
      n_fail++; $display("FAIL trunc_b2 got v%b e%b mty%0d fc %0d dc %0d want 1 1 34 7 0", ether_data_valid, ether_data_eop, ether_data_mty, frame_count, drop_count);
    end
  endtask

  // Runt frame of 12 bytes
  task automatic test_runt();
    step(pat(8'h60), 1'b1, 1'b1, 1'b1, 8'd52);
    n_checks++;
    if ({ether_header_valid, ether_data_valid, err} !== 3'b001 || drop_count !== 32'd1 || frame_count !== 32'd7) begin
      n_fail++; $display("FAIL runt got hv%b dv%b err%b dc %0d fc %0d want 0 0 1 1 7", ether_header_valid, ether_data_valid, err, drop_count, frame_count);
    end
    step(512'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL runt_pulse got err%b want 0", err);
    end
  endtask

  // Reset asserted while a frame is in BODY, then a fresh frame
  task automatic test_reset_mid();
    logic [511:0] d;
    d = pat(8'h33);
    step(pat(8'h11), 1'b1, 1'b1, 1'b0, 8'd0);
    step(pat(8'h22), 1'b1, 1'b0, 1'b0, 8'd0);
    reset_n = 1'b0;
    step(512'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if ({ether_header_valid, ether_data_valid, ether_data_eop, err} !== 4'b0000 || ether_data_data !== 512'd0 || frame_count !== 32'd0 || drop_count !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_zero got dv%b e%b fc %0d dc %0d want 0 0 0 0", ether_data_valid, ether_data_eop, frame_count, drop_count);
    end
    reset_n = 1'b1;
    step(512'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if (ether_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_noeop got v%b want 0", ether_data_valid);
    end
    step(d, 1'b1, 1'b1, 1'b1, 8'd0);
    n_checks++;
    if ({ether_header_valid, ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty} !== {4'b1111, 8'd14} || ether_data_data !== {d[399:0], 112'd0} || frame_count !== 32'd1) begin
      n_fail++; $display("FAIL rstmid_frame got hv%b v%b s%b e%b mty%0d fc %0d want 1 1 1 1 14 1", ether_header_valid, ether_data_valid, ether_data_sop, ether_data_eop, ether_data_mty, frame_count);
    end
  endtask

  // Scenario sequence
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    recv_data  = 512'd0;
    recv_valid = 1'b0;
    recv_sop   = 1'b0;
    recv_eop   = 1'b0;
    recv_mty   = 8'd0;
    test_reset();
    test_single_beat();
    test_two_beat();
    test_short_tail();
    test_gap();
    test_back_to_back();
    test_truncated();
    test_runt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
